// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM encoding, the NOP
// returned on faulting fetches, and the word-range check used by both address ports.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StLoad  = 2'd1,
    StDrain = 2'd2
  } arb_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // True when the word addressed by byte_addr lies beyond a memory of depth words.
  function automatic logic word_out_of_range(logic [63:0] byte_addr, int unsigned depth);
    return (byte_addr >> 2) >= 64'(depth);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the CPU fetch port, the loader port and the instruction RAM port.
// slave is the arbiter's view; master is the surrounding CPU/loader/RAM.
interface imem_arbiter_if #(
  parameter int unsigned INSTRUCTION_BITSIZE      = 32,
  parameter int unsigned INSTRUCTION_MEMORY_DEPTH = 256
);

  localparam int unsigned MemAddrWidth = $clog2(INSTRUCTION_MEMORY_DEPTH);

  logic                           load_mode;

  logic                           fetch_valid;
  logic                           fetch_ready;
  logic [INSTRUCTION_BITSIZE-1:0] fetch_addr;
  logic                           fetch_rsp_valid;
  logic [INSTRUCTION_BITSIZE-1:0] fetch_rsp_data;
  logic                           fetch_rsp_err;

  logic                           ld_valid;
  logic                           ld_ready;
  logic [INSTRUCTION_BITSIZE-1:0] ld_addr;
  logic [INSTRUCTION_BITSIZE-1:0] ld_wdata;
  logic                           ld_err;
  logic                           load_done;

  logic [MemAddrWidth-1:0]        mem_addr;
  logic                           mem_we;
  logic [INSTRUCTION_BITSIZE-1:0] mem_wdata;
  logic [INSTRUCTION_BITSIZE-1:0] mem_rdata;

  modport slave (
    input  load_mode,
    input  fetch_valid, fetch_addr,
    output fetch_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
    input  ld_valid, ld_addr, ld_wdata,
    output ld_ready, ld_err, load_done,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output load_mode,
    output fetch_valid, fetch_addr,
    input  fetch_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
    output ld_valid, ld_addr, ld_wdata,
    input  ld_ready, ld_err, load_done,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_addr_check.sv
// Combinational byte-address decode: word index plus misaligned / out-of-range flags.
module imem_addr_check
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned Depth     = 256,
  localparam int unsigned IdxWidth = $clog2(Depth)
) (
  input  logic [AddrWidth-1:0] addr_i,
  output logic [IdxWidth-1:0]  word_idx_o,
  output logic                 misaligned_o,
  output logic                 out_of_range_o
);

  assign word_idx_o     = addr_i[IdxWidth+1:2];
  assign misaligned_o   = |addr_i[1:0];
  assign out_of_range_o = word_out_of_range(64'(addr_i), Depth);

endmodule

// File: rtl/imem_arbiter.sv
// Shares one synchronous instruction RAM between CPU fetches and a loader session
// (RUN -> LOAD -> DRAIN -> RUN); faulting fetches return a NOP with an error flag.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned INSTRUCTION_BITSIZE      = 32,
  parameter int unsigned INSTRUCTION_MEMORY_DEPTH = 256
) (
  input  logic           clk,
  input  logic           reset,
  imem_arbiter_if.slave  bus
);

  localparam int unsigned W  = INSTRUCTION_BITSIZE;
  localparam int unsigned Aw = $clog2(INSTRUCTION_MEMORY_DEPTH);

  arb_state_e    state_q, state_d;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic          ld_err_q;
  logic [Aw-1:0] mem_addr_q, mem_addr_d;

  logic [Aw-1:0] fetch_idx, ld_idx;
  logic          fetch_mis, fetch_oor, ld_mis, ld_oor;
  logic          fetch_fire, fetch_bad, ld_fire, ld_bad;

  imem_addr_check #(
    .AddrWidth (W),
    .Depth     (INSTRUCTION_MEMORY_DEPTH)
  ) u_fetch_check (
    .addr_i         (bus.fetch_addr),
    .word_idx_o     (fetch_idx),
    .misaligned_o   (fetch_mis),
    .out_of_range_o (fetch_oor)
  );

  imem_addr_check #(
    .AddrWidth (W),
    .Depth     (INSTRUCTION_MEMORY_DEPTH)
  ) u_ld_check (
    .addr_i         (bus.ld_addr),
    .word_idx_o     (ld_idx),
    .misaligned_o   (ld_mis),
    .out_of_range_o (ld_oor)
  );

  // fetch_ready is low whenever load_mode is high, so no fetch can be in flight
  // across the RUN->LOAD edge; a response already returning this cycle completes.
  always_comb begin
    state_d         = state_q;
    bus.fetch_ready = 1'b0;
    bus.ld_ready    = 1'b0;
    unique case (state_q)
      StRun: begin
        bus.fetch_ready = !bus.load_mode && !reset;
        if (bus.load_mode) state_d = StLoad;
      end
      StLoad: begin
        // A write arriving as load_mode falls is not taken.
        bus.ld_ready = bus.load_mode && !reset;
        if (!bus.load_mode) state_d = StDrain;
      end
      StDrain: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  assign fetch_fire = bus.fetch_valid & bus.fetch_ready;
  assign fetch_bad  = fetch_mis | fetch_oor;
  assign ld_fire    = bus.ld_valid & bus.ld_ready;
  assign ld_bad     = ld_mis | ld_oor;

  // RAM address is held between accesses; faulting requests never touch it.
  always_comb begin
    mem_addr_d = mem_addr_q;
    bus.mem_we = 1'b0;
    if (ld_fire && !ld_bad) begin
      mem_addr_d = ld_idx;
      bus.mem_we = 1'b1;
    end else if (fetch_fire && !fetch_bad) begin
      mem_addr_d = fetch_idx;
    end
  end

  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = bus.ld_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ld_err_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= fetch_fire;
      rsp_err_q   <= fetch_fire & fetch_bad;
      ld_err_q    <= ld_fire & ld_bad;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // RAM data arrives one cycle after the address, aligned with rsp_valid_q.
  always_comb begin
    bus.fetch_rsp_data = '0;
    if (rsp_valid_q) begin
      bus.fetch_rsp_data = rsp_err_q ? W'(NopInstr) : bus.mem_rdata;
    end
  end

  assign bus.fetch_rsp_valid = rsp_valid_q;
  assign bus.fetch_rsp_err   = rsp_err_q;
  assign bus.ld_err          = ld_err_q;
  assign bus.load_done       = (state_q == StDrain);

  a_we_only_in_load : assert property (
    @(posedge clk) disable iff (reset) bus.mem_we |-> (state_q == StLoad));

  a_ports_exclusive : assert property (
    @(posedge clk) disable iff (reset) !(fetch_fire && ld_fire));

  a_drain_one_cycle : assert property (
    @(posedge clk) disable iff (reset) bus.load_done |=> (state_q == StRun));

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: fetch expectations are queued at issue and
// popped by a monitor on each response strobe; loader/FSM behaviour checked inline.
module tb_imem_arbiter;

  logic clk;
  logic reset;

  imem_arbiter_if #(
    .INSTRUCTION_BITSIZE      (32),
    .INSTRUCTION_MEMORY_DEPTH (256)
  ) bus_if ();

  imem_arbiter #(
    .INSTRUCTION_BITSIZE      (32),
    .INSTRUCTION_MEMORY_DEPTH (256)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM model; word i holds 0x1000_0000 + i after reset.
  logic [31:0] ram [256];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h1000_0000 + 32'(i);
      bus_if.mem_rdata <= '0;
    end else begin
      if (bus_if.mem_we) ram[bus_if.mem_addr] <= bus_if.mem_wdata;
      bus_if.mem_rdata <= ram[bus_if.mem_addr];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (bus_if.fetch_rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%0h required no response",
                 bus_if.fetch_rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", bus_if.fetch_rsp_data, mon_e.data);
        check("rsp_err", 32'(bus_if.fetch_rsp_err), 32'(mon_e.err));
        check("rsp_latency", 32'(cyc), 32'(mon_e.cyc + 1));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Issue one fetch for a cycle; expected RAM address is hand-supplied.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                       input logic exp_err, input logic [31:0] exp_mem_addr);
    exp_t e;
    step();
    bus_if.fetch_valid = 1'b1;
    bus_if.fetch_addr  = addr;
    sample();
    check("fetch_ready", 32'(bus_if.fetch_ready), 32'd1);
    check("fetch_mem_addr", 32'(bus_if.mem_addr), exp_mem_addr);
    e.data = exp_data;
    e.err  = exp_err;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("rst_rsp_valid", 32'(bus_if.fetch_rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus_if.fetch_rsp_err), 32'd0);
    check("rst_rsp_data", bus_if.fetch_rsp_data, 32'd0);
    check("rst_ld_err", 32'(bus_if.ld_err), 32'd0);
    check("rst_load_done", 32'(bus_if.load_done), 32'd0);
    check("rst_mem_we", 32'(bus_if.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
    check("rst_fetch_ready", 32'(bus_if.fetch_ready), 32'd0);
  endtask

  initial begin
    reset              = 1'b1;
    bus_if.load_mode   = 1'b0;
    bus_if.fetch_valid = 1'b0;
    bus_if.fetch_addr  = '0;
    bus_if.ld_valid    = 1'b0;
    bus_if.ld_addr     = '0;
    bus_if.ld_wdata    = '0;

    step();
    step();
    sample();
    check_reset_outputs();

    step();
    reset = 1'b0;
    sample();
    check("run_fetch_ready", 32'(bus_if.fetch_ready), 32'd1);
    check("run_ld_ready", 32'(bus_if.ld_ready), 32'd0);

    // Back-to-back good fetches, then misaligned and out-of-range.
    fetch(32'h0000_0000, 32'h1000_0000, 1'b0, 32'd0);
    fetch(32'h0000_0004, 32'h1000_0001, 1'b0, 32'd1);
    fetch(32'h0000_0008, 32'h1000_0002, 1'b0, 32'd2);
    fetch(32'h0000_0006, 32'h0000_0013, 1'b1, 32'd2);
    fetch(32'h0000_0400, 32'h0000_0013, 1'b1, 32'd2);
    step();
    bus_if.fetch_valid = 1'b0;
    sample();

    // Loader session.
    step();
    bus_if.load_mode = 1'b1;
    sample();
    check("lm_fetch_ready", 32'(bus_if.fetch_ready), 32'd0);
    check("lm_ld_ready_run", 32'(bus_if.ld_ready), 32'd0);

    step();
    bus_if.ld_valid = 1'b1;
    bus_if.ld_addr  = 32'h0000_0010;
    bus_if.ld_wdata = 32'hDEAD_BEEF;
    sample();
    check("load_ld_ready", 32'(bus_if.ld_ready), 32'd1);
    check("load_mem_we", 32'(bus_if.mem_we), 32'd1);
    check("load_mem_addr", 32'(bus_if.mem_addr), 32'd4);
    check("load_mem_wdata", bus_if.mem_wdata, 32'hDEAD_BEEF);

    step();
    bus_if.ld_addr  = 32'h0000_0003;
    bus_if.ld_wdata = 32'h1234_5678;
    sample();
    check("bad_ld_mem_we", 32'(bus_if.mem_we), 32'd0);
    check("bad_ld_err_early", 32'(bus_if.ld_err), 32'd0);

    step();
    bus_if.ld_valid = 1'b0;
    sample();
    check("bad_ld_err_pulse", 32'(bus_if.ld_err), 32'd1);

    // load_mode falls with a write pending: write must be dropped.
    step();
    bus_if.ld_valid  = 1'b1;
    bus_if.ld_addr   = 32'h0000_0020;
    bus_if.ld_wdata  = 32'hCAFE_F00D;
    bus_if.load_mode = 1'b0;
    sample();
    check("exit_mem_we", 32'(bus_if.mem_we), 32'd0);
    check("exit_ld_err", 32'(bus_if.ld_err), 32'd0);

    step();
    bus_if.ld_valid = 1'b0;
    sample();
    check("drain_load_done", 32'(bus_if.load_done), 32'd1);
    check("drain_fetch_ready", 32'(bus_if.fetch_ready), 32'd0);

    fetch(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'd4);
    check("run_load_done", 32'(bus_if.load_done), 32'd0);
    fetch(32'h0000_0020, 32'h1000_0008, 1'b0, 32'd8);

    // load_mode rises while a response is returning.
    fetch(32'h0000_000C, 32'h1000_0003, 1'b0, 32'd3);
    step();
    bus_if.fetch_addr = 32'h0000_0014;
    bus_if.load_mode  = 1'b1;
    sample();
    check("race_fetch_ready", 32'(bus_if.fetch_ready), 32'd0);

    step();
    bus_if.fetch_valid = 1'b0;
    sample();
    check("race_ld_ready", 32'(bus_if.ld_ready), 32'd1);
    check("race_load_done", 32'(bus_if.load_done), 32'd0);

    // Reset mid-LOAD overrides a pending write and a pending fetch.
    step();
    reset           = 1'b1;
    bus_if.ld_valid = 1'b1;
    bus_if.ld_addr  = 32'h0000_0018;
    bus_if.ld_wdata = 32'hBAD0_BAD0;
    sample();
    check("rst_ld_ready", 32'(bus_if.ld_ready), 32'd0);
    check("rst_ld_mem_we", 32'(bus_if.mem_we), 32'd0);

    step();
    bus_if.ld_valid    = 1'b0;
    bus_if.load_mode   = 1'b0;
    bus_if.fetch_valid = 1'b1;
    bus_if.fetch_addr  = 32'h0000_0000;
    sample();
    check_reset_outputs();

    step();
    reset              = 1'b0;
    bus_if.fetch_valid = 1'b0;
    sample();
    check("post_rst_fetch_ready", 32'(bus_if.fetch_ready), 32'd1);
    check("post_rst_ld_ready", 32'(bus_if.ld_ready), 32'd0);
    check("post_rst_rsp_valid", 32'(bus_if.fetch_rsp_valid), 32'd0);

    step();
    step();
    sample();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
